// File: rtl/pc_pkg.sv
// Shared constants for the program counter and the control FSM that drives it.
package pc_pkg;

   localparam int PC_WIDTH  = 16;
   localparam int RAS_DEPTH = 4;

   // Next-PC source encoding on PCSEL
   localparam logic [1:0] SEL_INC = 2'd0;
   localparam logic [1:0] SEL_REL = 2'd1;
   localparam logic [1:0] SEL_DIR = 2'd2;
   localparam logic [1:0] SEL_RET = 2'd3;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular array with a top pointer and a separate count.
// When full, a push overwrites the oldest entry so the newest DEPTH addresses survive.
module ras_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     PUSH,
   input  logic                     POP,
   input  logic [WIDTH-1:0]         DIN,
   output logic [WIDTH-1:0]         TOP,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     EMPTY,
   output logic                     FULL,
   output logic                     OVF_EV,
   output logic                     UNF_EV
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_inc;
   logic [PW-1:0]    ptr_dec;
   logic [CW-1:0]    count;

   assign ptr_inc = ptr + 1'b1;
   assign ptr_dec = ptr - 1'b1;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ptr   <= '0;
         count <= '0;
      end else if (PUSH) begin
         ptr <= ptr_inc;
         if (count != FULL_CNT) count <= count + 1'b1;
      end else if (POP && (count != '0)) begin
         ptr   <= ptr_dec;
         count <= count - 1'b1;
      end
   end

   // Contents are don't-care after reset, so the array itself is not reset
   always_ff @(posedge CLK) begin
      if (!RESET && PUSH) mem[ptr_inc] <= DIN;
   end

   assign TOP    = mem[ptr];
   assign COUNT  = count;
   assign EMPTY  = (count == '0);
   assign FULL   = (count == FULL_CNT);
   assign OVF_EV = PUSH && FULL;
   assign UNF_EV = POP && EMPTY;

endmodule

// File: rtl/pc_ras.sv
// Program counter with four next-PC sources and an internal return-address stack.
// Calls via PCSEL REL/DIR push PC+1; PCSEL RET pops into the PC.
module pc_ras
   import pc_pkg::*;
#(
   parameter int               WIDTH     = PC_WIDTH,
   parameter int               DEPTH     = RAS_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     LD,
   input  logic [1:0]               PCSEL,
   input  logic                     CALL,
   input  logic [WIDTH-1:0]         OFFSET,
   input  logic [WIDTH-1:0]         DIRECT,
   input  logic                     CLR_ERR,
   output logic [WIDTH-1:0]         PC_OUT,
   output logic [$clog2(DEPTH):0]   RAS_COUNT,
   output logic                     RAS_EMPTY,
   output logic                     RAS_FULL,
   output logic                     OVF,
   output logic                     UNF
);

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] ras_top;
   logic             push;
   logic             pop;
   logic             ovf_ev;
   logic             unf_ev;
   logic             ovf_q;
   logic             unf_q;

   assign pc_inc = pc + 1'b1;
   assign push   = LD && CALL && ((PCSEL == SEL_REL) || (PCSEL == SEL_DIR));
   assign pop    = LD && (PCSEL == SEL_RET);

   ras_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ras (
      .CLK    (CLK),
      .RESET  (RESET),
      .PUSH   (push),
      .POP    (pop),
      .DIN    (pc_inc),
      .TOP    (ras_top),
      .COUNT  (RAS_COUNT),
      .EMPTY  (RAS_EMPTY),
      .FULL   (RAS_FULL),
      .OVF_EV (ovf_ev),
      .UNF_EV (unf_ev)
   );

   // OFFSET is relative to the current PC, not PC+1; a pop from an empty stack holds
   always_comb begin
      pc_next = pc;
      case (PCSEL)
         SEL_INC: pc_next = pc_inc;
         SEL_REL: pc_next = pc + OFFSET;
         SEL_DIR: pc_next = DIRECT;
         SEL_RET: pc_next = RAS_EMPTY ? pc : ras_top;
         default: pc_next = pc;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pc <= RESET_VEC;
      end else if (LD) begin
         pc <= pc_next;
      end
   end

   // Sticky error flags: a new event in the same cycle wins over CLR_ERR
   always_ff @(posedge CLK) begin
      if (RESET) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (ovf_ev)       ovf_q <= 1'b1;
         else if (CLR_ERR) ovf_q <= 1'b0;
         if (unf_ev)       unf_q <= 1'b1;
         else if (CLR_ERR) unf_q <= 1'b0;
      end
   end

   assign PC_OUT = pc;
   assign OVF    = ovf_q;
   assign UNF    = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras: increment, relative/wrap, call/return, overflow,
// underflow, hold, flag clearing and reset in the middle of a call sequence.
module tb_pc_ras;

   logic        CLK;
   logic        RESET;
   logic        LD;
   logic [1:0]  PCSEL;
   logic        CALL;
   logic [15:0] OFFSET;
   logic [15:0] DIRECT;
   logic        CLR_ERR;
   logic [15:0] PC_OUT;
   logic [2:0]  RAS_COUNT;
   logic        RAS_EMPTY;
   logic        RAS_FULL;
   logic        OVF;
   logic        UNF;

   int checks;
   int errors;

   pc_ras #(
      .WIDTH     (16),
      .DEPTH     (4),
      .RESET_VEC (16'h0000)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .LD        (LD),
      .PCSEL     (PCSEL),
      .CALL      (CALL),
      .OFFSET    (OFFSET),
      .DIRECT    (DIRECT),
      .CLR_ERR   (CLR_ERR),
      .PC_OUT    (PC_OUT),
      .RAS_COUNT (RAS_COUNT),
      .RAS_EMPTY (RAS_EMPTY),
      .RAS_FULL  (RAS_FULL),
      .OVF       (OVF),
      .UNF       (UNF)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // apply inputs then advance one clock; outputs are sampled 1ns after the edge
   task automatic step(input logic rst, input logic ld, input logic [1:0] sel,
                       input logic call, input logic [15:0] off, input logic [15:0] dir,
                       input logic clr);
      RESET   = rst;
      LD      = ld;
      PCSEL   = sel;
      CALL    = call;
      OFFSET  = off;
      DIRECT  = dir;
      CLR_ERR = clr;
      @(posedge CLK);
      #1;
   endtask

   task automatic set_pc(input logic [15:0] v);
      step(1'b0, 1'b1, 2'd2, 1'b0, 16'h0, v, 1'b0);
   endtask

   logic [15:0] ret_exp [4];
   logic [2:0]  cnt_exp [4];

   initial begin
      checks = 0;
      errors = 0;
      RESET = 1'b0; LD = 1'b0; PCSEL = 2'd0; CALL = 1'b0;
      OFFSET = '0; DIRECT = '0; CLR_ERR = 1'b0;
      #2;

      // reset state
      step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0);
      check("rst_pc",    32'(PC_OUT),    32'h0);
      check("rst_count", 32'(RAS_COUNT), 32'h0);
      check("rst_empty", 32'(RAS_EMPTY), 32'h1);
      check("rst_full",  32'(RAS_FULL),  32'h0);
      check("rst_ovf",   32'(OVF),       32'h0);
      check("rst_unf",   32'(UNF),       32'h0);

      // increment
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0);
         check("inc_pc", 32'(PC_OUT), 32'(i));
      end
      check("inc_empty", 32'(RAS_EMPTY), 32'h1);
      check("inc_ovf",   32'(OVF),       32'h0);
      check("inc_unf",   32'(UNF),       32'h0);

      // relative with negative offset from PC=3
      step(1'b0, 1'b1, 2'd1, 1'b0, 16'hFFFE, 16'h0, 1'b0);
      check("rel_pc", 32'(PC_OUT), 32'h0001);

      // increment wraps at all-ones
      set_pc(16'hFFFF);
      check("dir_pc", 32'(PC_OUT), 32'hFFFF);
      step(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0);
      check("wrap_pc", 32'(PC_OUT), 32'h0000);

      // call / return
      set_pc(16'h0010);
      step(1'b0, 1'b1, 2'd2, 1'b1, 16'h0, 16'h0100, 1'b0);
      check("call_pc",    32'(PC_OUT),    32'h0100);
      check("call_count", 32'(RAS_COUNT), 32'h1);
      step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0);
      check("ret_pc",    32'(PC_OUT),    32'h0011);
      check("ret_empty", 32'(RAS_EMPTY), 32'h1);

      // CALL with PCSEL=0 does not push
      step(1'b0, 1'b1, 2'd0, 1'b1, 16'h0, 16'h0, 1'b0);
      check("inc_call_pc",    32'(PC_OUT),    32'h0012);
      check("inc_call_count", 32'(RAS_COUNT), 32'h0);

      // relative call pushes PC+1, return comes back
      step(1'b0, 1'b1, 2'd1, 1'b1, 16'h0020, 16'h0, 1'b0);
      check("relcall_pc",    32'(PC_OUT),    32'h0032);
      check("relcall_count", 32'(RAS_COUNT), 32'h1);
      step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0);
      check("relret_pc", 32'(PC_OUT), 32'h0013);

      // five nested calls into a four-deep stack
      for (int i = 1; i <= 5; i++) begin
         set_pc(16'(i * 16));
         step(1'b0, 1'b1, 2'd2, 1'b1, 16'h0, 16'h0200, 1'b0);
         if (i == 4) begin
            check("fill_full", 32'(RAS_FULL), 32'h1);
            check("fill_ovf",  32'(OVF),      32'h0);
         end
      end
      check("ovf_flag",  32'(OVF),       32'h1);
      check("ovf_count", 32'(RAS_COUNT), 32'h4);

      ret_exp[0] = 16'h0051; ret_exp[1] = 16'h0041;
      ret_exp[2] = 16'h0031; ret_exp[3] = 16'h0021;
      cnt_exp[0] = 3'd3; cnt_exp[1] = 3'd2; cnt_exp[2] = 3'd1; cnt_exp[3] = 3'd0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0);
         check("ovf_ret_pc",    32'(PC_OUT),    32'(ret_exp[i]));
         check("ovf_ret_count", 32'(RAS_COUNT), 32'(cnt_exp[i]));
      end
      check("pre_unf", 32'(UNF), 32'h0);
      step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0);
      check("unf_flag",  32'(UNF),       32'h1);
      check("unf_pc",    32'(PC_OUT),    32'h0021);
      check("unf_count", 32'(RAS_COUNT), 32'h0);

      // LD=0 holds everything
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 2'd3, 1'b1, 16'h0, 16'h0, 1'b0);
         check("hold_pc",    32'(PC_OUT),    32'h0021);
         check("hold_count", 32'(RAS_COUNT), 32'h0);
         check("hold_ovf",   32'(OVF),       32'h1);
         check("hold_unf",   32'(UNF),       32'h1);
      end
      step(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b1);
      check("clr_ovf", 32'(OVF),    32'h0);
      check("clr_unf", 32'(UNF),    32'h0);
      check("clr_pc",  32'(PC_OUT), 32'h0021);

      // underflow in the same cycle as CLR_ERR: set wins
      step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b1);
      check("setwin_unf", 32'(UNF), 32'h1);
      check("setwin_ovf", 32'(OVF), 32'h0);
      step(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b1);
      check("clr2_unf", 32'(UNF), 32'h0);

      // reset in the middle of a call sequence
      set_pc(16'h0100);
      step(1'b0, 1'b1, 2'd2, 1'b1, 16'h0, 16'h0200, 1'b0);
      step(1'b0, 1'b1, 2'd2, 1'b1, 16'h0, 16'h0300, 1'b0);
      check("mid_count", 32'(RAS_COUNT), 32'h2);
      step(1'b1, 1'b1, 2'd3, 1'b1, 16'h0, 16'h0, 1'b0);
      check("mid_rst_pc",    32'(PC_OUT),    32'h0000);
      check("mid_rst_count", 32'(RAS_COUNT), 32'h0);
      check("mid_rst_empty", 32'(RAS_EMPTY), 32'h1);
      step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0);
      check("mid_unf",    32'(UNF),    32'h1);
      check("mid_unf_pc", 32'(PC_OUT), 32'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised successor to the LC-3 program counter.
- Holds a WIDTH-bit PC and selects the next PC from four sources:
  - increment (PC+1),
  - PC-relative offset,
  - absolute target,
  - return address popped from an internal return-address stack (RAS).
- Calls (JSR/JSRR) push the link address onto the RAS; returns pop it.
- Sits in the datapath where the old pc block sat; driven by the control FSM.

Parameters:
- WIDTH, 16: PC and address width in bits.
- DEPTH, 4: RAS entries; power of two, minimum 2.
- RESET_VEC, 0: PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- LD  in  1  PC load enable; when 0, no state changes except CLR_ERR.
- PCSEL  in  2  next-PC source: 0=PC+1, 1=PC+OFFSET, 2=DIRECT, 3=RAS pop.
- CALL  in  1  with LD=1 and PCSEL 1 or 2, push PC+1 onto the RAS.
- OFFSET  in  WIDTH  two's-complement displacement, already sign-extended.
- DIRECT  in  WIDTH  absolute jump target.
- CLR_ERR  in  1  clears the OVF and UNF sticky flags.
- PC_OUT  out  WIDTH  current PC (register output).
- RAS_COUNT  out  $clog2(DEPTH)+1  number of valid RAS entries.
- RAS_EMPTY  out  1  RAS_COUNT==0.
- RAS_FULL  out  1  RAS_COUNT==DEPTH.
- OVF  out  1  sticky: a push happened while the RAS was full.
- UNF  out  1  sticky: a pop was attempted while the RAS was empty.

Behaviour:
- Clock and reset
  - Single clock domain.
  - RESET is synchronous, active-high, and overrides all other inputs.
  - On reset: PC_OUT=RESET_VEC, RAS_COUNT=0, RAS_EMPTY=1, RAS_FULL=0, OVF=0, UNF=0.
  - Stack contents are don't-care after reset.
  - Reset asserted mid call/return sequence discards all stack state.
- Timing
  - All outputs are registered or decoded from registers; no combinational input-to-output path.
  - Latency is one cycle: a load in cycle n is visible on PC_OUT in cycle n+1.
- Next-PC arithmetic
  - All arithmetic is modulo 2^WIDTH.
  - PC+1 at all-ones wraps to 0.
  - PC+OFFSET: OFFSET is added to the current PC_OUT, not to PC+1. The caller pre-adjusts if it needs LC-3 semantics.
- LD=0
  - PC, RAS and flags hold.
  - CALL and PCSEL are ignored.
  - CLR_ERR still acts.
- PCSEL=0 or 1 or 2 with LD=1
  - PC loads the selected source.
  - If CALL=1 and PCSEL is 1 or 2, PC+1 (the pre-update PC plus one) is pushed.
  - CALL with PCSEL 0 or 3 is ignored and causes no push.
- Push while full
  - Entry is written over the oldest (circular buffer).
  - RAS_COUNT stays at DEPTH.
  - OVF sets.
  - The most recent DEPTH return addresses are preserved.
- PCSEL=3 with LD=1, RAS not empty
  - PC loads the top entry.
  - RAS_COUNT decrements.
- PCSEL=3 with LD=1, RAS empty
  - PC holds its value.
  - UNF sets.
  - RAS_COUNT stays 0.
- CLR_ERR
  - Clears OVF and UNF in the same cycle.
  - If a new overflow or underflow event occurs in the same cycle, set wins over clear.
- RAS implementation
  - Circular array with a top pointer of log2(DEPTH) bits and a separate count.
  - Push: pointer increments then writes.
  - Pop: reads at the pointer then decrements.
  - Pointer wraps modulo DEPTH.
- PCSEL is a 2-bit encoding and every value is defined.

Decomposition:
- Package pc_pkg:
  - PCSEL localparams: SEL_INC=0, SEL_REL=1, SEL_DIR=2, SEL_RET=3.
  - Default WIDTH and DEPTH constants shared with the control FSM.
- Sub-module ras_stack #(WIDTH, DEPTH):
  - Inputs: CLK, RESET, PUSH, POP, DIN.
  - Outputs: TOP, COUNT, EMPTY, FULL, OVF_EV, UNF_EV.
  - Holds the circular array, pointer and count.
- pc_ras holds the PC register, adder, source mux and sticky flags.
- The existing inc1 and mux16 helpers are not reused, because they are fixed at 16 bits.

Test Plan:
- Reset then increment: RESET=1 for one cycle, then LD=1, PCSEL=0 for 3 cycles -> PC_OUT 0,1,2,3; RAS_EMPTY=1, OVF=0, UNF=0.
- Relative and wrap:
  - PC=0x0003, LD=1, PCSEL=1, OFFSET=0xFFFE -> PC_OUT=0x0001.
  - PC=0xFFFF, PCSEL=0 -> PC_OUT=0x0000.
- Call/return:
  - PC=0x0010, CALL=1, PCSEL=2, DIRECT=0x0100 -> PC_OUT=0x0100, RAS_COUNT=1.
  - Then PCSEL=3 -> PC_OUT=0x0011, RAS_EMPTY=1.
- Nested overflow (DEPTH=4):
  - 5 calls from PCs 0x10,0x20,0x30,0x40,0x50 -> OVF=1, RAS_COUNT=4.
  - Then 4 returns -> PC_OUT sequence 0x51,0x41,0x31,0x21.
  - Then a 5th return -> UNF=1 and PC holds 0x21.
- Hold and clear: LD=0 with CALL=1, PCSEL=3 for 2 cycles -> PC and RAS_COUNT unchanged. Then CLR_ERR=1 -> OVF=0, UNF=0.
- Reset mid-sequence: after 2 calls, assert RESET -> PC_OUT=RESET_VEC, RAS_COUNT=0. A following PCSEL=3 sets UNF.
